// File: rtl/bin_erode_3x3.sv
// bin_erode_3x3
//   Thresholds an 8-bit luma stream to a 1-bit mask, erodes it with a 3x3
//   structuring element built from two 1-bit line buffers, and emits a
//   0x00/0xFF luma stream for the connected-component labeler downstream.
//   Frame/line framing passes through with a fixed 3-clock delay.
//
// Build option:
//   ERODE_EDGE_ZERO_EN  defined   -> window cells outside the image count as 0
//                       undefined -> window cells outside the image count as 1
//
// Ports:
//   clk               pixel clock
//   rst_n             asynchronous active-low reset
//   per_frame_vsync   input frame valid (high for the whole frame)
//   per_frame_href    input pixel valid
//   per_img_Y         input luma
//   thresh            binarization threshold, captured at each frame start
//   post_frame_vsync  per_frame_vsync delayed 3 clocks
//   post_frame_href   per_frame_href delayed 3 clocks
//   post_img_Y        eroded pixel, 8'hFF foreground / 8'h00 background
//   line_len_err      one-clock pulse after a line whose length != IMG_HDISP
module bin_erode_3x3 #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int COL_W     = 11,
    parameter int ROW_W     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic [7:0] per_img_Y,
    input  logic [7:0] thresh,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic [7:0] post_img_Y,
    output logic       line_len_err
);

    localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam logic [COL_W-1:0] HDISP_C = COL_W'(IMG_HDISP);
    localparam logic [ROW_W-1:0] VDISP_C = ROW_W'(IMG_VDISP);

`ifdef ERODE_EDGE_ZERO_EN
    localparam logic OOF_VAL = 1'b0;
`else
    localparam logic OOF_VAL = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Front end: frame tracking, threshold, counters
    // ------------------------------------------------------------------
    logic             vs_prev;
    logic             armed;
    logic             frame_act;
    logic             href_prev;
    logic [7:0]       thr_q;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic             vs_rise;
    logic             live;
    logic             vs_in;
    logic             href_in;
    logic             href_fall;
    logic [7:0]       thr_eff;
    logic [ROW_W-1:0] cur_row;
    logic             col_in;
    logic [AW-1:0]    addr;
    logic             rd1;
    logic             rd2;
    logic             pix_bin;

    logic             lb1 [IMG_HDISP];
    logic             lb2 [IMG_HDISP];

    // A frame is only accepted after a genuine low-to-high vsync edge seen
    // since reset ('armed' requires vsync to have been low first), so a
    // reset released mid-frame discards the rest of that frame.
    always_comb begin
        vs_rise   = per_frame_vsync & ~vs_prev & armed;
        live      = frame_act | vs_rise;
        vs_in     = per_frame_vsync & live;
        href_in   = per_frame_href & live;
        href_fall = href_prev & ~href_in;
        // Bypass so a first pixel coinciding with the vsync edge already
        // uses the new threshold and row 0.
        thr_eff   = vs_rise ? thresh : thr_q;
        cur_row   = vs_rise ? '0 : row;
        col_in    = (col < HDISP_C);
        addr      = col[AW-1:0];
        rd1       = col_in ? lb1[addr] : 1'b0;
        rd2       = col_in ? lb2[addr] : 1'b0;
        pix_bin   = (per_img_Y >= thr_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev      <= 1'b0;
            armed        <= 1'b0;
            frame_act    <= 1'b0;
            href_prev    <= 1'b0;
            thr_q        <= 8'd128;
            col          <= '0;
            row          <= '0;
            line_len_err <= 1'b0;
        end else begin
            vs_prev      <= per_frame_vsync;
            armed        <= armed | ~per_frame_vsync;
            frame_act    <= per_frame_vsync & live;
            href_prev    <= href_in;
            if (vs_rise)
                thr_q <= thresh;
            if (href_in) begin
                if (col != '1)
                    col <= col + 1'b1;
            end else if (href_fall) begin
                col <= '0;
            end
            if (vs_rise)
                row <= '0;
            else if (href_fall && (row != VDISP_C))
                row <= row + 1'b1;
            line_len_err <= href_fall && (col != HDISP_C);
        end
    end

    // Read-before-write: the old lb1 entry (row r-1) moves into lb2.
    always_ff @(posedge clk) begin
        if (href_in && col_in) begin
            lb1[addr] <= pix_bin;
            lb2[addr] <= lb1[addr];
        end
    end

    // ------------------------------------------------------------------
    // S1: binarized pixel and row-masked line buffer taps
    // ------------------------------------------------------------------
    logic s1_vs, s1_href, s1_bin, s1_up1, s1_up2;
    logic s1_r_ge1, s1_c_ge1, s1_c_ge2, s1_c_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vs    <= 1'b0;
            s1_href  <= 1'b0;
            s1_bin   <= 1'b0;
            s1_up1   <= 1'b0;
            s1_up2   <= 1'b0;
            s1_r_ge1 <= 1'b0;
            s1_c_ge1 <= 1'b0;
            s1_c_ge2 <= 1'b0;
            s1_c_in  <= 1'b0;
        end else begin
            s1_vs    <= vs_in;
            s1_href  <= href_in;
            s1_bin   <= pix_bin;
            s1_up1   <= (|cur_row) ? rd1 : OOF_VAL;
            s1_up2   <= (|cur_row[ROW_W-1:1]) ? rd2 : OOF_VAL;
            s1_r_ge1 <= |cur_row;
            s1_c_ge1 <= |col;
            s1_c_ge2 <= |col[COL_W-1:1];
            s1_c_in  <= col_in;
        end
    end

    // ------------------------------------------------------------------
    // S2: window shift registers, bit 0 = column c, bit 2 = column c-2
    // ------------------------------------------------------------------
    logic [2:0] w_r0, w_r1, w_r2;
    logic       s2_vs, s2_href, s2_r_ge1, s2_c_ge1, s2_c_ge2, s2_c_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_r0     <= '0;
            w_r1     <= '0;
            w_r2     <= '0;
            s2_vs    <= 1'b0;
            s2_href  <= 1'b0;
            s2_r_ge1 <= 1'b0;
            s2_c_ge1 <= 1'b0;
            s2_c_ge2 <= 1'b0;
            s2_c_in  <= 1'b0;
        end else begin
            if (s1_href) begin
                w_r0 <= {w_r0[1:0], s1_bin};
                w_r1 <= {w_r1[1:0], s1_up1};
                w_r2 <= {w_r2[1:0], s1_up2};
            end
            s2_vs    <= s1_vs;
            s2_href  <= s1_href;
            s2_r_ge1 <= s1_r_ge1;
            s2_c_ge1 <= s1_c_ge1;
            s2_c_ge2 <= s1_c_ge2;
            s2_c_in  <= s1_c_in;
        end
    end

    // ------------------------------------------------------------------
    // S3: column masking, 9-input AND, output register
    // ------------------------------------------------------------------
    // Older taps still hold the previous line at the start of a line, so
    // columns c-1/c-2 are replaced by the out-of-frame value there.
    logic [2:0] m_r0, m_r1, m_r2;
    logic       pix_on;

    always_comb begin
        m_r0   = {s2_c_ge2 ? w_r0[2] : OOF_VAL, s2_c_ge1 ? w_r0[1] : OOF_VAL, w_r0[0]};
        m_r1   = {s2_c_ge2 ? w_r1[2] : OOF_VAL, s2_c_ge1 ? w_r1[1] : OOF_VAL, w_r1[0]};
        m_r2   = {s2_c_ge2 ? w_r2[2] : OOF_VAL, s2_c_ge1 ? w_r2[1] : OOF_VAL, w_r2[0]};
        pix_on = s2_href & s2_c_in & s2_r_ge1 & s2_c_ge1 & (&{m_r0, m_r1, m_r2});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_img_Y       <= '0;
        end else begin
            post_frame_vsync <= s2_vs;
            post_frame_href  <= s2_href;
            post_img_Y       <= pix_on ? 8'hFF : 8'h00;
        end
    end

endmodule

// File: tb/tb_bin_erode_3x3.sv
// Testbench for bin_erode_3x3 on a 16x8 image. Captures the output image,
// compares it pixel by pixel against a software erosion of the input mask,
// and checks framing delay, line_len_err timing and reset behaviour.
module tb_bin_erode_3x3;

    localparam int W = 16;
    localparam int H = 8;

`ifdef ERODE_EDGE_ZERO_EN
    localparam bit OOF = 1'b0;
`else
    localparam bit OOF = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vs, hr;
    logic [7:0] y, thresh;
    logic       post_vs, post_hr, lle;
    logic [7:0] post_y;

    always #5 clk = ~clk;

    bin_erode_3x3 #(
        .IMG_HDISP(W),
        .IMG_VDISP(H),
        .COL_W(5),
        .ROW_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .per_frame_vsync(vs),
        .per_frame_href(hr),
        .per_img_Y(y),
        .thresh(thresh),
        .post_frame_vsync(post_vs),
        .post_frame_href(post_hr),
        .post_img_Y(post_y),
        .line_len_err(lle)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] img  [H][W];
    bit         bimg [H][W];
    logic [7:0] cap  [H][W];

    // ---------------- output monitor ----------------
    int         orow = 0, ocol = 0, npix = 0, hcnt = 0;
    int         lle_cnt = 0, zero_err = 0, delay_err = 0;
    int         ri;
    logic       pv_prev = 1'b0, ph_prev = 1'b0;
    logic [1:0] hist [3];
    logic       chk_delay = 1'b0;

    always_comb ri = (post_vs && !pv_prev) ? 0 : orow;

    always @(negedge clk) begin
        pv_prev <= post_vs;
        ph_prev <= post_hr;
        if (post_hr) begin
            if (ri < H && ocol < W) cap[ri][ocol] <= post_y;
            ocol <= ocol + 1;
            orow <= ri;
        end else begin
            ocol <= 0;
            orow <= ph_prev ? ri + 1 : ri;
        end
        npix <= ((post_vs && !pv_prev) ? 0 : npix) + (post_hr ? 1 : 0);
        hcnt <= hcnt + (post_hr ? 1 : 0);
        if (lle) lle_cnt <= lle_cnt + 1;
        if (!post_hr && post_y != 8'h00) zero_err <= zero_err + 1;
        hist[0] <= {vs, hr};
        hist[1] <= hist[0];
        hist[2] <= hist[1];
        if (chk_delay && ({post_vs, post_hr} !== hist[2])) delay_err <= delay_err + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int r, input int c);
        if (r == 0 || c == 0) return 8'h00;
        for (int dr = -2; dr <= 0; dr++)
            for (int dc = -2; dc <= 0; dc++) begin
                bit v;
                v = (r + dr < 0 || c + dc < 0) ? OOF : bimg[r + dr][c + dc];
                if (!v) return 8'h00;
            end
        return 8'hFF;
    endfunction

    task automatic fill(input logic [7:0] v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = ($urandom_range(0, 9) < 8) ? 8'd200 : 8'd20;
    endtask

    task automatic mkbin(input logic [7:0] thr);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) bimg[r][c] = (img[r][c] >= thr);
    endtask

    task automatic drive_line(input int r, input int len, input int gap, input bit lle_chk);
        for (int c = 0; c < len; c++) begin
            hr = 1'b1;
            y  = img[r][c];
            tick();
        end
        hr = 1'b0;
        y  = 8'h5A;
        for (int g = 0; g < gap; g++) begin
            if (lle_chk && g < 3) begin
                @(negedge clk);
                chk($sformatf("lle_t%0d", g), 32'(lle), (g == 1) ? 32'd1 : 32'd0);
            end
            tick();
        end
    endtask

    task automatic run_frame(input logic [7:0] thr, input int chg_row, input logic [7:0] thr2,
                             input int lead, input int gap, input int short_row);
        vs = 1'b0;
        hr = 1'b0;
        repeat (4) tick();
        chk_delay = 1'b1;
        thresh = thr;
        vs = 1'b1;
        for (int i = 0; i < lead; i++) tick();
        for (int r = 0; r < H; r++) begin
            if (r == chg_row) thresh = thr2;
            drive_line(r, (r == short_row) ? W - 1 : W, (r == H - 1) ? 2 : gap, r == short_row);
        end
        vs = 1'b0;
        repeat (5) tick();
    endtask

    task automatic compare_frame(input string name, input int skip_r, input int skip_c, input int exp_n);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (!(r == skip_r && c == skip_c))
                    chk($sformatf("%s_px%0d_%0d", name, r, c), 32'(cap[r][c]), 32'(exp_pix(r, c)));
        chk($sformatf("%s_npix", name), 32'(npix), 32'(exp_n));
    endtask

    // ---------------- directed sequence ----------------
    int lle0, h0;

    initial begin
        rst_n  = 1'b0;
        vs     = 1'b0;
        hr     = 1'b0;
        y      = 8'h00;
        thresh = 8'd128;
        repeat (3) tick();
        chk("reset_vsync", 32'(post_vs), 32'd0);
        chk("reset_href",  32'(post_hr), 32'd0);
        chk("reset_y",     32'(post_y),  32'd0);
        chk("reset_lle",   32'(lle),     32'd0);
        rst_n = 1'b1;
        tick();

        // Solid foreground, 1-clock href gaps
        fill(8'd200); mkbin(8'd128);
        lle0 = lle_cnt;
        run_frame(8'd128, -1, 8'd0, 2, 1, -1);
        compare_frame("all200", -1, -1, W * H);
        chk("all200_px1_1", 32'(cap[1][1]), 32'hFF);
        chk("all200_lle", 32'(lle_cnt - lle0), 32'd0);

        // Isolated pixel erodes away
        fill(8'd10); img[4][5] = 8'd255; mkbin(8'd128);
        run_frame(8'd128, -1, 8'd0, 1, 2, -1);
        compare_frame("iso", -1, -1, W * H);

        // 3x3 block centred at (4,5) leaves one pixel at output (5,6)
        fill(8'd10);
        for (int r = 3; r <= 5; r++)
            for (int c = 4; c <= 6; c++) img[r][c] = 8'd255;
        mkbin(8'd128);
        run_frame(8'd128, -1, 8'd0, 1, 2, -1);
        compare_frame("blk", -1, -1, W * H);
        chk("blk_hit", 32'(cap[5][6]), 32'hFF);
        chk("blk_ctr", 32'(cap[4][5]), 32'h00);

        // Threshold 250 -> nothing survives
        fill(8'd150); mkbin(8'd250);
        run_frame(8'd250, -1, 8'd0, 1, 2, -1);
        compare_frame("thr250", -1, -1, W * H);

        // Threshold 100 at frame start (coincident first href), 250 mid-frame
        fill(8'd150); mkbin(8'd100);
        run_frame(8'd100, 3, 8'd250, 0, 2, -1);
        compare_frame("thrmid", -1, -1, W * H);

        // Short line on row 2
        fill(8'd200); mkbin(8'd128);
        lle0 = lle_cnt;
        run_frame(8'd128, -1, 8'd0, 1, 3, 2);
        compare_frame("short", 2, W - 1, W * H - 1);
        chk("short_lle_cnt", 32'(lle_cnt - lle0), 32'd1);

        // Reset in the middle of row 3
        chk_delay = 1'b0;
        fill_rand();
        vs = 1'b0; hr = 1'b0;
        repeat (4) tick();
        thresh = 8'd128;
        vs = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) drive_line(r, W, 2, 1'b0);
        for (int c = 0; c < 4; c++) begin
            hr = 1'b1; y = img[3][c]; tick();
        end
        chk("pre_rst_href", 32'(post_hr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_vsync", 32'(post_vs), 32'd0);
        chk("rst_href",  32'(post_hr), 32'd0);
        chk("rst_y",     32'(post_y),  32'd0);
        tick(); tick();
        rst_n = 1'b1;
        h0 = hcnt;
        for (int r = 4; r < 6; r++) drive_line(r, W, 2, 1'b0);
        repeat (3) tick();
        chk("no_emit", 32'(hcnt - h0), 32'd0);

        fill_rand(); mkbin(8'd128);
        run_frame(8'd128, -1, 8'd0, 1, 2, -1);
        compare_frame("post_rst", -1, -1, W * H);

        // Back-to-back random frames with 5-cycle gaps
        lle0 = lle_cnt;
        for (int f = 0; f < 2; f++) begin
            fill_rand(); mkbin(8'd128);
            run_frame(8'd128, -1, 8'd0, 1, 5, -1);
            compare_frame($sformatf("rnd%0d", f), -1, -1, W * H);
        end
        chk("rnd_lle", 32'(lle_cnt - lle0), 32'd0);

        chk("zero_when_idle", 32'(zero_err), 32'd0);
        chk("frame_delay3", 32'(delay_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
